uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide ready/valid in, 8N1 UART frames out on
// serial_out, LSB first. One bit lasts CLOCK_FREQ/BAUD_RATE clocks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   undefined : 8N1, 10-bit frames, PARITY_ODD unused, no parity logic
//   defined   : 8-bit data + parity (even if PARITY_ODD=0, odd if 1) + stop,
//               11-bit frames
module uart_tx_serializer #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       busy
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  // Guard the width so a bad configuration reaches the elaboration error
  // below rather than tripping over a zero-width vector first.
  localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam int BIT_W = $clog2(FRAME_BITS);

  // Terminal counts, sized to the counters so every compare is width-exact.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  // Configuration sanity: a symbol must last at least two clocks, and the
  // parity sense is a single-bit choice.
  generate
    if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLOCK_FREQ/BAUD_RATE must be >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q,      state_d;
  logic [CNT_W-1:0]        clk_cnt_q,    clk_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q,    bit_cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q,      shreg_d;
  logic                    serial_out_q, serial_out_d;

  logic                    fire;
  logic [FRAME_BITS-1:0]   frame;

  // Handshake: ready depends on state alone, so a producer may sample it
  // before deciding to raise valid without forming a loop.
  assign data_in_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign fire          = data_in_valid & data_in_ready;
  assign serial_out    = serial_out_q;

  // --------------------------------------------------------------------------
  // Frame assembly: bit 0 goes out first, so the start bit sits at the LSB
  // and the stop bit at the MSB.
  // --------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  // Even parity makes the total count of ones even; odd sense inverts it.
  assign parity_bit = (^data_in) ^ (PARITY_ODD != 0);
  assign frame      = {1'b1, parity_bit, data_in, 1'b0};
`else
  assign frame      = {1'b1, data_in, 1'b0};
`endif

  // --------------------------------------------------------------------------
  // Next-state logic: counters, shifter and registered line value.
  // --------------------------------------------------------------------------
  // Compute next state, counters, shift register and the next line level.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    serial_out_d = serial_out_q;

    case (state_q)
      IDLE: begin
        // Counters parked at zero so every frame starts from a clean count.
        clk_cnt_d    = '0;
        bit_cnt_d    = '0;
        serial_out_d = 1'b1;
        if (fire) begin
          // Load the whole frame now; data_in is free to change afterwards.
          shreg_d      = frame;
          state_d      = SEND;
          // Start bit appears on the line the cycle after the handshake.
          serial_out_d = frame[0];
        end
      end

      SEND: begin
        if (clk_cnt_q == CNT_LAST) begin
          // Symbol boundary: advance to the next bit, back-filling with the
          // idle level so the register drains to all ones.
          clk_cnt_d = '0;
          shreg_d   = {1'b1, shreg_q[FRAME_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            // Stop bit has had its full time; ready returns next cycle.
            state_d      = IDLE;
            bit_cnt_d    = '0;
            serial_out_d = 1'b1;
          end else begin
            bit_cnt_d    = bit_cnt_q + 1'b1;
            serial_out_d = shreg_d[0];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        // Unreachable with a 1-bit encoding; recover to a safe idle line.
        state_d      = IDLE;
        clk_cnt_d    = '0;
        bit_cnt_d    = '0;
        shreg_d      = '1;
        serial_out_d = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers. Reset drives the line high immediately, abandoning any frame
  // in flight; nothing of the old frame survives into the next one.
  // --------------------------------------------------------------------------
  // State, counter, shifter and output-line flops with async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '1;
      serial_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      serial_out_q <= serial_out_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer with a 10-clock symbol time.
// Expected line levels come from a frame list built per byte
// (start, data LSB first, optional parity, stop) indexed by elapsed cycles.
module tb_uart_tx_serializer;

  localparam int CF   = 1000;
  localparam int BR   = 100;
  localparam int T    = CF / BR;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_tx_serializer #(
    .CLOCK_FREQ (CF),
    .BAUD_RATE  (BR),
    .PARITY_ODD (PODD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level j cycles after the start bit begins.
  function automatic logic exp_line(input logic [7:0] b, input int j);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^b) ^ (PODD != 0));
`endif
    bits.push_back(1'b1);
    return bits[j / T];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_line"},  serial_out,    1'b1);
    check({tag, "_ready"}, data_in_ready, 1'b1);
    check({tag, "_busy"},  busy,          1'b0);
  endtask

  // Present b, take the handshake on the next edge, then check the whole
  // frame cycle by cycle. keep_valid leaves valid high (with junk data)
  // through the frame; pulse_at>=0 raises valid with 0x3C for one cycle.
  task automatic fire_byte(input logic [7:0] b, input bit keep_valid,
                           input int pulse_at);
    check("ready_before_fire", data_in_ready, 1'b1);
    data_in       = b;
    data_in_valid = 1'b1;
    step();
    data_in_valid = keep_valid;
    data_in       = 8'($urandom);
    for (int j = 0; j < FB * T; j++) begin
      check("frame_line",  serial_out,    exp_line(b, j));
      check("frame_ready", data_in_ready, 1'b0);
      check("frame_busy",  busy,          1'b1);
      if (j == pulse_at) begin
        data_in       = 8'h3C;
        data_in_valid = 1'b1;
      end else if (!keep_valid) begin
        data_in_valid = 1'b0;
      end
      step();
    end
    check_idle("after_stop");
  endtask

  initial begin
    logic [7:0] b;
    int gap;

    // Reset held for 5 cycles, then 100 quiet cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("in_reset");
    end
    #3 reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check_idle("post_reset");
    end

    // Single byte 0xA5 with known line pattern and ready at fire+101.
    fire_byte(8'hA5, 1'b0, -1);
    step();
    check_idle("a5_quiet");

    // Back-to-back with valid held: 0x00 then 0xFF, one idle cycle between.
    fire_byte(8'h00, 1'b1, -1);
    fire_byte(8'hFF, 1'b1, -1);
    data_in_valid = 1'b0;
    step();
    check_idle("b2b_quiet");

    // Valid pulse with 0x3C in the middle of a 0x55 frame must be ignored.
    fire_byte(8'h55, 1'b0, 30);
    for (int i = 0; i < 3 * T; i++) begin
      step();
      check_idle("no_3c_sent");
    end

    // Asynchronous reset during data bit 3.
    b = 8'($urandom);
    data_in       = b;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    for (int j = 0; j < 4 * T + 3; j++) begin
      check("pre_abort_line", serial_out, exp_line(b, j));
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    check_idle("abort_now");
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      step();
      check_idle("abort_release");
    end
    fire_byte(8'($urandom), 1'b0, -1);

    // Randomized bytes with random idle gaps.
    for (int n = 0; n < 8; n++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        check_idle("rand_gap");
      end
      fire_byte(b, ($urandom_range(0, 1) == 1), -1);
      data_in_valid = 1'b0;
    end

`ifdef UART_TX_PARITY_EN
    // Parity-specific bytes: 0x07 (three ones) and 0x03 (two ones).
    fire_byte(8'h07, 1'b0, -1);
    fire_byte(8'h03, 1'b0, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
